// File: rtl/popcount_bcd_display.sv
// popcount_bcd_display: serial popcount -> double-dabble BCD -> multiplexed active-low 7-seg scan.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant nonzero digit.
module popcount_bcd_display #(
  parameter int IN_W        = 9,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  localparam int CNT_W      = $clog2(IN_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in,
  output logic [CNT_W-1:0]  count,
  output logic              upd,
  output logic [DIGITS-1:0] digit_sel,
  output logic [6:0]        seg,
  output logic              DP
);
  localparam int BW = 4 * DIGITS;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int XW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, COUNT, CONVERT, LATCH} state_t;
  state_t st_q, st_d;
  logic [IN_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] acc_q, acc_d, step_q, step_d, count_q, count_d;
  logic [BW-1:0] bcd_q, bcd_d, adj, disp_q, disp_d;
  logic upd_q;
  logic [RW-1:0] ref_q;
  logic [XW-1:0] idx_q;
  logic [3:0] nib;
  logic [DIGITS-1:0] blank;
  logic [6:0] dec;
`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;
`endif
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
  end
  // CONVERT rotates the accumulator, so after CNT_W steps it holds the popcount again for LATCH
  always_comb begin
    st_d = st_q;
    sh_d = sh_q;
    acc_d = acc_q;
    step_d = step_q;
    bcd_d = bcd_q;
    count_d = count_q;
    disp_d = disp_q;
    case (st_q)
      IDLE: begin
        sh_d = in;
        acc_d = '0;
        step_d = '0;
        bcd_d = '0;
        st_d = COUNT;
      end
      COUNT: begin
        sh_d = sh_q >> 1;
        acc_d = acc_q + CNT_W'(sh_q[0]);
        step_d = step_q == CNT_W'(IN_W - 1) ? '0 : step_q + CNT_W'(1);
        st_d = step_q == CNT_W'(IN_W - 1) ? CONVERT : COUNT;
      end
      CONVERT: begin
        bcd_d = {adj[BW-2:0], acc_q[CNT_W-1]};
        acc_d = (acc_q << 1) | (acc_q >> (CNT_W - 1));
        step_d = step_q + CNT_W'(1);
        st_d = step_q == CNT_W'(CNT_W - 1) ? LATCH : CONVERT;
      end
      default: begin
        count_d = acc_q;
        disp_d = bcd_q;
        st_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= IDLE;
      sh_q <= '0;
      acc_q <= '0;
      step_q <= '0;
      bcd_q <= '0;
      count_q <= '0;
      disp_q <= '0;
      upd_q <= 1'b0;
      ref_q <= '0;
      idx_q <= '0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      step_q <= step_d;
      bcd_q <= bcd_d;
      count_q <= count_d;
      disp_q <= disp_d;
      upd_q <= st_q == LATCH;
      ref_q <= ref_q == RW'(REFRESH_DIV - 1) ? '0 : ref_q + RW'(1);
      if (ref_q == RW'(REFRESH_DIV - 1))
        idx_q <= idx_q == XW'(DIGITS - 1) ? '0 : idx_q + XW'(1);
    end
  end
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && disp_q[4*k +: 4] == 4'd0;
      blank[k] = zero_run;
    end
`endif
  end
  assign nib = disp_q[{idx_q, 2'b00} +: 4];
  always_comb begin
    case (nib)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  end
  assign seg = blank[idx_q] ? 7'b1111111 : dec;
  assign digit_sel = ~(DIGITS'(1) << idx_q);
  assign count = count_q;
  assign upd = upd_q;
  assign DP = 1'b1;
endmodule

// File: doc/popcount_bcd_display.md
# popcount_bcd_display

Parametrised successor to the lab 4 ones-counter display path. Each conversion period the block samples an `IN_W`-bit input and counts its set bits serially. It converts the count to BCD with a sequential shift-add-3 (double-dabble) engine and shows the result on a `DIGITS`-digit time-multiplexed 7-segment display. Intended as the top-level datapath for board labs with arbitrary switch counts and display widths.

## Interface
Parameters:
- `IN_W`, default 9: input vector width. Legal range 1 to 10^DIGITS−1.
- `DIGITS`, default 4: number of multiplexed digits. Legal range 1 to 8.
- `REFRESH_DIV`, default 100000: clock cycles each digit stays selected. Minimum 2.
- Derived `CNT_W` = $clog2(IN_W+1): width of the popcount.

Ports:
- `clk`, input, 1: sole clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in`, input, IN_W: bits to count. Sampled once per period.
- `count`, output, CNT_W: last completed popcount, binary, registered.
- `upd`, output, 1: one-cycle pulse marking that `count` and the display value were just refreshed.
- `digit_sel`, output, DIGITS: active-low one-hot digit enable. Bit 0 is the units digit.
- `seg`, output, 7: active-low segments, ordered {g,f,e,d,c,b,a}.
- `DP`, output, 1: decimal point. Constant 1 (off).

## Operation
- Conversion FSM states: IDLE → COUNT → CONVERT → LATCH → IDLE. The FSM free-runs and has no start input.
  - IDLE (1 cycle): copy `in` into a shadow register. Clear the accumulator.
  - COUNT (IN_W cycles): shift the shadow register right by one each cycle and add bit 0 to the accumulator.
  - CONVERT (CNT_W cycles): double-dabble. Before each shift, add 3 to any BCD nibble ≥5, then shift the accumulator MSB into the BCD register.
  - LATCH (1 cycle): copy the accumulator to `count` and the BCD register to the display register. Assert `upd` on the following cycle.
- BCD register width is 4·DIGITS. Nibble k is decimal digit k.
- Display scan:
  - A refresh counter runs 0..REFRESH_DIV−1.
  - On wrap, the digit index advances and wraps from DIGITS−1 to 0.
  - `digit_sel` = ~(1 << index).
  - `seg` = decode(display nibble[index]). Encodings: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Any nibble >9 drives 1111111. This cannot occur in legal configurations.
- The display register changes only in LATCH, so there is no tearing mid-scan. A change to `in` during COUNT or CONVERT takes effect in the next period.
- Reset mid-conversion aborts the period. No partial result reaches `count` or the display.

## Timing
- Conversion period P = IN_W + CNT_W + 2 cycles. With defaults P = 15.
- After `rst_n` is released, the FSM is in IDLE in the first cycle. The first `upd` occurs in cycle P (0-based), and repeats every P cycles thereafter.
- Latency is P cycles from the sampling edge (IDLE) to the `upd` cycle. `count` is valid from the `upd` cycle on.
- Reset values:
  - FSM = IDLE, `count` = 0, `upd` = 0.
  - Display register = 0, refresh counter = 0, digit index = 0.
  - `digit_sel` = all ones except bit 0 = 0.
  - `seg` = 1000000, `DP` = 1.
- Each digit is selected for exactly REFRESH_DIV cycles. Full scan = DIGITS·REFRESH_DIV cycles.
- Scan and conversion are independent. A LATCH coinciding with a digit-index advance shows the new value on the new digit in the same cycle.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Any nibble above the most significant nonzero nibble drives `seg` = 1111111. Its `digit_sel` bit still cycles, so scan timing is unchanged.
  - The units digit is never blanked, so a value of 0 shows as a single "0".
- Not defined: all digits are shown, with leading zeros (e.g. "0007").

## Test plan
- Reset and hold `rst_n`=0 for 5 cycles → `count`=0, `upd`=0, `digit_sel`=1110, `seg`=1000000, `DP`=1.
- Defaults with REFRESH_DIV=4, `in`=9'h1FF → first `upd` at cycle 15 after release, `count`=9. Units digit `seg`=0010000. Upper digits show 1000000 without the macro, 1111111 with it.
- `in`=9'h0A5 held, then changed to 9'h000 during COUNT → that period reports 4. The next period reports 0, and `upd` spacing stays exactly 15.
- IN_W=12, DIGITS=2, `in`=12'hFFF → `count`=12, display nibbles {1,2}. Units digit `seg`=0100100, tens digit `seg`=1111001.
- REFRESH_DIV=4, DIGITS=4 → `digit_sel` sequence 1110, 1101, 1011, 0111, 1110, each held for exactly 4 cycles.
- Assert `rst_n`=0 for 1 cycle in mid-CONVERT → no `upd` for that period. `count` returns to 0, and the next `upd` comes P cycles after release.
